// File: rtl/multi_context_pc_unit.sv
// Fetch-side program counter with per-context saved PCs, prioritised redirects
// and a two-state save/restore FSM for scheduler-driven context swaps.
module multi_context_pc_unit #(
  parameter int              NUM_CTX    = 2,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h6000_0000,
  parameter logic [XLEN-1:0] CTX_STRIDE = 32'h0001_0000,
  parameter int              INST_BYTES = 4,
  parameter int              CTX_W      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_prev,
  output logic [CTX_W-1:0] ctx_id,
  input  logic             flush,
  input  logic [XLEN-1:0]  flush_pc,
  input  logic             br_en,
  input  logic [XLEN-1:0]  br_pc,
  input  logic             jump_en,
  input  logic [XLEN-1:0]  jump_pc,
  input  logic             jalr_done,
  input  logic [XLEN-1:0]  jalr_pc,
  input  logic             swap_req,
  input  logic [CTX_W-1:0] swap_ctx,
  output logic             swap_ack,
  output logic             swap_err
);

  typedef enum logic {RUN, SWAP} state_t;

  localparam logic [CTX_W:0] NUM_CTX_L = (CTX_W + 1)'(NUM_CTX);

  state_t            state, state_next;
  logic [XLEN-1:0]   ctx_pc [NUM_CTX];
  logic [CTX_W-1:0]  target;
  logic [XLEN-1:0]   pc_lo, prev_lo;
  logic              ctx_in_range, swap_go;

  function automatic logic [XLEN-1:0] ctx_reset_pc(input int idx);
    logic [63:0] acc;
    acc = 64'(RESET_PC) + 64'(CTX_STRIDE) * 64'(unsigned'(idx));
    return acc[XLEN-1:0];
  endfunction

  // Next PC ignoring any swap; this is also the value saved for the outgoing context.
  always_comb begin
    pc_lo   = pc;
    prev_lo = pc_prev;
    if (flush)          pc_lo = flush_pc;
    else if (br_en)     pc_lo = br_pc;
    else if (jump_en)   pc_lo = jump_pc;
    else if (jalr_done) pc_lo = jalr_pc;
    else if (fetch_valid && fetch_ready) begin
      pc_lo   = pc + XLEN'(INST_BYTES);
      prev_lo = pc;
    end
  end

  always_comb begin
    ctx_in_range = ({1'b0, swap_ctx} < NUM_CTX_L);
    swap_go      = swap_req && ctx_in_range && (swap_ctx != ctx_id);
    state_next   = state;
    case (state)
      RUN:     if (swap_go) state_next = SWAP;
      SWAP:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_valid <= 1'b0;
      swap_ack    <= 1'b0;
      swap_err    <= 1'b0;
      ctx_id      <= '0;
      pc          <= RESET_PC;
      pc_prev     <= RESET_PC;
      for (int i = 0; i < NUM_CTX; i++) ctx_pc[i] <= ctx_reset_pc(i);
    end else begin
      state       <= state_next;
      fetch_valid <= (state_next == RUN);
      swap_ack    <= 1'b0;
      swap_err    <= 1'b0;
      case (state)
        RUN: begin
          swap_err <= swap_req && !ctx_in_range;
          swap_ack <= swap_req && ctx_in_range && (swap_ctx == ctx_id);
          if (swap_go) begin
            ctx_pc[ctx_id] <= pc_lo;
            target         <= swap_ctx;
          end else begin
            pc      <= pc_lo;
            pc_prev <= prev_lo;
          end
        end
        SWAP: begin
          // ctx_id still names the outgoing context during this cycle.
          if (flush) ctx_pc[ctx_id] <= flush_pc;
          pc       <= ctx_pc[target];
          pc_prev  <= ctx_pc[target];
          ctx_id   <= target;
          swap_ack <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_context_pc_unit.sv
// Randomised and directed bench for multi_context_pc_unit (three contexts)
// against a cycle-level behavioural model of the PC/context rules.
module tb_multi_context_pc_unit;

  localparam int NC = 3;
  localparam logic [31:0] RPC = 32'h6000_0000;
  localparam logic [31:0] STR = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst, fetch_ready, fetch_valid;
  logic [31:0] pc, pc_prev;
  logic [1:0]  ctx_id, swap_ctx;
  logic        flush, br_en, jump_en, jalr_done, swap_req, swap_ack, swap_err;
  logic [31:0] flush_pc, br_pc, jump_pc, jalr_pc;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_ctx [NC];
  logic [31:0] m_pc, m_prev;
  int          m_id, m_tgt;
  bit          m_swap, m_fv, m_ack, m_err;

  always #5 clk = ~clk;

  multi_context_pc_unit #(.NUM_CTX(NC)) dut (
    .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .pc(pc), .pc_prev(pc_prev), .ctx_id(ctx_id),
    .flush(flush), .flush_pc(flush_pc), .br_en(br_en), .br_pc(br_pc),
    .jump_en(jump_en), .jump_pc(jump_pc), .jalr_done(jalr_done), .jalr_pc(jalr_pc),
    .swap_req(swap_req), .swap_ctx(swap_ctx), .swap_ack(swap_ack), .swap_err(swap_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_ctx[i] = RPC + STR * i;
    m_pc = RPC; m_prev = RPC; m_id = 0; m_swap = 0;
    m_fv = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_step();
    logic [31:0] np, npp;
    bit in_rng;
    if (rst) begin
      model_reset();
    end else if (m_swap) begin
      if (flush) m_ctx[m_id] = flush_pc;
      m_pc = m_ctx[m_tgt]; m_prev = m_ctx[m_tgt];
      m_id = m_tgt; m_swap = 0; m_fv = 1; m_ack = 1; m_err = 0;
    end else begin
      np = m_pc; npp = m_prev;
      if (flush)          np = flush_pc;
      else if (br_en)     np = br_pc;
      else if (jump_en)   np = jump_pc;
      else if (jalr_done) np = jalr_pc;
      else if (m_fv && fetch_ready) begin np = m_pc + 32'd4; npp = m_pc; end
      in_rng = (int'(swap_ctx) < NC);
      m_err  = swap_req && !in_rng;
      m_ack  = swap_req && in_rng && (int'(swap_ctx) == m_id);
      if (swap_req && in_rng && int'(swap_ctx) != m_id) begin
        m_ctx[m_id] = np; m_tgt = int'(swap_ctx); m_swap = 1; m_fv = 0;
      end else begin
        m_pc = np; m_prev = npp; m_fv = 1;
      end
    end
  endtask

  task automatic clr();
    rst = 0; fetch_ready = 0; flush = 0; br_en = 0; jump_en = 0; jalr_done = 0; swap_req = 0;
    swap_ctx = 0; flush_pc = 0; br_pc = 0; jump_pc = 0; jalr_pc = 0;
  endtask

  task automatic tick();
    check("fetch_valid", 32'(fetch_valid), 32'(m_fv));
    check("ctx_id", 32'(ctx_id), 32'(m_id));
    check("swap_ack", 32'(swap_ack), 32'(m_ack));
    check("swap_err", 32'(swap_err), 32'(m_err));
    if (!m_swap) begin
      check("pc", pc, m_pc);
      check("pc_prev", pc_prev, m_prev);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    clr();
    rst = 1;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check("rst_pc", pc, RPC);
    check("rst_fv", 32'(fetch_valid), 32'd0);
    rst = 0;

    // Sequential fetch after reset
    fetch_ready = 1;
    repeat (4) tick();
    check("seq_pc", pc, 32'h6000_000C);
    check("seq_prev", pc_prev, 32'h6000_0008);

    // Redirects while stalled
    clr(); br_en = 1; br_pc = 32'h6000_0100; tick();
    check("br_pc", pc, 32'h6000_0100);
    check("br_prev", pc_prev, 32'h6000_0008);
    flush = 1; flush_pc = 32'h6000_0200; tick();
    check("flush_pc", pc, 32'h6000_0200);
    clr(); br_en = 1; br_pc = 32'h6000_0010; tick();

    // Swap 0 -> 1 and back
    clr(); fetch_ready = 1; swap_req = 1; swap_ctx = 1; tick();
    check("swap_bubble", 32'(fetch_valid), 32'd0);
    clr(); fetch_ready = 1; tick();
    check("swap_in_pc", pc, 32'h6001_0000);
    check("swap_in_ctx", 32'(ctx_id), 32'd1);
    check("swap_in_ack", 32'(swap_ack), 32'd1);
    swap_req = 1; swap_ctx = 0; tick();
    clr(); fetch_ready = 1; tick();
    check("swap_back_pc", pc, 32'h6000_0014);

    // Jump saved on swap-out, flush during SWAP overrides it
    swap_req = 1; swap_ctx = 1; jump_en = 1; jump_pc = 32'h6000_0400; tick();
    clr(); flush = 1; flush_pc = 32'h6000_0500; tick();
    clr(); swap_req = 1; swap_ctx = 0; tick();
    clr(); tick();
    check("flush_saved_pc", pc, 32'h6000_0500);

    // Out-of-range and self swap
    fetch_ready = 1; swap_req = 1; swap_ctx = 3; tick();
    check("err_pulse", 32'(swap_err), 32'd1);
    check("err_pc", pc, 32'h6000_0504);
    swap_ctx = 0; tick();
    check("self_ack", 32'(swap_ack), 32'd1);
    check("self_fv", 32'(fetch_valid), 32'd1);

    // Reset during SWAP
    swap_ctx = 2; tick();
    clr(); rst = 1; tick();
    check("rst_swap_pc", pc, RPC);
    check("rst_swap_ctx", 32'(ctx_id), 32'd0);
    check("rst_swap_fv", 32'(fetch_valid), 32'd0);
    clr(); fetch_ready = 1; swap_req = 1; swap_ctx = 2; tick(); tick();
    clr(); tick();
    check("ctx2_reset_pc", pc, 32'h6002_0000);

    // Wrap-around
    br_en = 1; br_pc = 32'hFFFF_FFFC; tick();
    clr(); fetch_ready = 1; tick();
    check("wrap_pc", pc, 32'h0000_0000);

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      rst         = ($urandom_range(0, 99) == 0);
      fetch_ready = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      br_en       = ($urandom_range(0, 11) == 0);
      jump_en     = ($urandom_range(0, 11) == 0);
      jalr_done   = ($urandom_range(0, 11) == 0);
      swap_req    = ($urandom_range(0, 6) == 0);
      swap_ctx    = 2'($urandom_range(0, 3));
      flush_pc    = $urandom() & 32'hFFFF_FFFC;
      br_pc       = $urandom() & 32'hFFFF_FFFC;
      jump_pc     = $urandom() & 32'hFFFF_FFFC;
      jalr_pc     = $urandom() & 32'hFFFF_FFFC;
      tick();
    end
    clr();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
